// File: rtl/obi_rr_arbiter_if.sv
// Bus bundle for the round-robin OBI arbiter: N master ports, one slave port,
// plus occupancy and spurious-response status.
interface obi_rr_arbiter_if #(
    parameter int NMASTER         = 3,
    parameter int MAX_OUTSTANDING = 2,
    parameter int LOG_OUT         = $clog2(MAX_OUTSTANDING + 1)
);
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    obi_req_t  [NMASTER-1:0] master_req_i;
    obi_resp_t [NMASTER-1:0] master_resp_o;
    obi_req_t                slave_req_o;
    obi_resp_t               slave_resp_i;
    logic      [LOG_OUT-1:0] outstanding_o;
    logic                    spurious_rvalid_o;

    modport slave (
        input  master_req_i,
        input  slave_resp_i,
        output master_resp_o,
        output slave_req_o,
        output outstanding_o,
        output spurious_rvalid_o
    );

    modport master (
        output master_req_i,
        output slave_resp_i,
        input  master_resp_o,
        input  slave_req_o,
        input  outstanding_o,
        input  spurious_rvalid_o
    );
endinterface

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI slave between NMASTER masters; an ID
// FIFO of granted master indices routes in-order responses back.
module obi_rr_arbiter #(
    parameter int NMASTER         = 3,
    parameter int MAX_OUTSTANDING = 2,
    parameter int LOG_NMASTER     = $clog2(NMASTER),
    parameter int LOG_OUT         = $clog2(MAX_OUTSTANDING + 1)
) (
    input logic            clk_i,
    input logic            rst_ni,
    obi_rr_arbiter_if.slave bus
);
    localparam int LOG_PTR = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [LOG_NMASTER-1:0] r_rr_ptr;
    logic [LOG_NMASTER-1:0] r_lock_idx;
    logic                   r_lock;
    logic [LOG_OUT-1:0]     r_count;
    logic [LOG_PTR-1:0]     r_rd_ptr;
    logic [LOG_PTR-1:0]     r_wr_ptr;
    logic [LOG_NMASTER-1:0] r_fifo [MAX_OUTSTANDING];
    logic                   r_spurious;

    logic [NMASTER-1:0]     w_req_vec;
    logic                   w_any;
    logic [LOG_NMASTER-1:0] w_search;
    logic [LOG_NMASTER-1:0] w_sel;
    logic [LOG_NMASTER-1:0] w_head;
    logic [LOG_NMASTER-1:0] w_rr_next;
    logic                   w_full;
    logic                   w_req;
    logic                   w_hs;
    logic                   w_pop;
    logic                   w_rvalid;

    function automatic logic [LOG_NMASTER-1:0] rr_idx(
        input logic [LOG_NMASTER-1:0] base,
        input int                     k
    );
        int s;
        s = int'(base) + k;
        if (s >= NMASTER) s = s - NMASTER;
        return s[LOG_NMASTER-1:0];
    endfunction

    function automatic logic [LOG_PTR-1:0] ptr_inc(input logic [LOG_PTR-1:0] p);
        if (p == LOG_PTR'(MAX_OUTSTANDING - 1)) return '0;
        return p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NMASTER; i++) begin
            w_req_vec[i] = bus.master_req_i[i].req;
        end
    end

    assign w_any = |w_req_vec;

    // Walk downwards so the lowest offset from rr_ptr wins
    always_comb begin
        w_search = r_rr_ptr;
        for (int k = NMASTER - 1; k >= 0; k--) begin
            if (w_req_vec[rr_idx(r_rr_ptr, k)]) w_search = rr_idx(r_rr_ptr, k);
        end
    end

    assign w_sel     = r_lock ? r_lock_idx : w_search;
    assign w_full    = (r_count == LOG_OUT'(MAX_OUTSTANDING));
    assign w_req     = rst_ni & (r_lock | w_any) & ~w_full;
    assign w_hs      = w_req & bus.slave_resp_i.gnt;
    assign w_rvalid  = rst_ni & bus.slave_resp_i.rvalid;
    assign w_pop     = w_rvalid & (r_count != '0);
    assign w_head    = r_fifo[r_rd_ptr];
    assign w_rr_next = (w_sel == LOG_NMASTER'(NMASTER - 1)) ? '0 : w_sel + 1'b1;

    always_comb begin
        bus.slave_req_o     = '0;
        bus.slave_req_o.req = w_req;
        if (r_lock | w_any) begin
            bus.slave_req_o.we    = bus.master_req_i[w_sel].we;
            bus.slave_req_o.be    = bus.master_req_i[w_sel].be;
            bus.slave_req_o.addr  = bus.master_req_i[w_sel].addr;
            bus.slave_req_o.wdata = bus.master_req_i[w_sel].wdata;
        end
    end

    always_comb begin
        for (int i = 0; i < NMASTER; i++) begin
            bus.master_resp_o[i].gnt    = w_hs & (w_sel == LOG_NMASTER'(i));
            bus.master_resp_o[i].rvalid = w_pop & (w_head == LOG_NMASTER'(i));
            bus.master_resp_o[i].rdata  = bus.slave_resp_i.rdata;
        end
    end

    assign bus.outstanding_o     = rst_ni ? r_count : '0;
    assign bus.spurious_rvalid_o = r_spurious;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_spurious <= 1'b0;
        end else begin
            r_spurious <= bus.slave_resp_i.rvalid & (r_count == '0);
            // Hold the choice until granted so the address phase stays stable
            if (w_hs) begin
                r_lock   <= 1'b0;
                r_rr_ptr <= w_rr_next;
            end else if (w_req) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_sel;
            end
            if (w_hs) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_hs && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_hs && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed and randomized bench for obi_rr_arbiter against a queue-based
// reference model of round-robin arbitration and in-order response routing.
module tb_obi_rr_arbiter;
    localparam int NM = 3;
    localparam int MO = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obi_rr_arbiter_if #(.NMASTER(NM), .MAX_OUTSTANDING(MO)) bus ();

    obi_rr_arbiter #(.NMASTER(NM), .MAX_OUTSTANDING(MO)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    logic        m_req   [NM];
    logic        m_we    [NM];
    logic [3:0]  m_be    [NM];
    logic [31:0] m_addr  [NM];
    logic [31:0] m_wdata [NM];
    logic        s_gnt;
    logic        s_rvalid;
    logic [31:0] s_rdata;

    int rr, lk_idx;
    bit lk, spur;
    int q[$];
    int e_sel;
    bit e_req;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_and_check();
        bit any, full, ev;
        for (int i = 0; i < NM; i++) begin
            bus.master_req_i[i].req   = m_req[i];
            bus.master_req_i[i].we    = m_we[i];
            bus.master_req_i[i].be    = m_be[i];
            bus.master_req_i[i].addr  = m_addr[i];
            bus.master_req_i[i].wdata = m_wdata[i];
        end
        bus.slave_resp_i.gnt    = s_gnt;
        bus.slave_resp_i.rvalid = s_rvalid;
        bus.slave_resp_i.rdata  = s_rdata;
        #1;
        any = 0;
        for (int i = 0; i < NM; i++) any |= m_req[i];
        e_sel = -1;
        if (lk) e_sel = lk_idx;
        else
            for (int k = 0; k < NM; k++)
                if (e_sel < 0 && m_req[(rr + k) % NM]) e_sel = (rr + k) % NM;
        full  = (q.size() == MO);
        e_req = rst_n && (lk || any) && !full;
        check("slave_req", bus.slave_req_o.req, e_req);
        if (e_req) begin
            check("slave_addr", bus.slave_req_o.addr, m_addr[e_sel]);
            check("slave_wdata", bus.slave_req_o.wdata, m_wdata[e_sel]);
        end else if (!lk && !any) begin
            check("idle_addr", bus.slave_req_o.addr, 32'h0);
        end
        for (int i = 0; i < NM; i++) begin
            check($sformatf("gnt%0d", i), bus.master_resp_o[i].gnt,
                  e_req && s_gnt && (i == e_sel));
            ev = rst_n && s_rvalid && (q.size() > 0) && (q[0] == i);
            check($sformatf("rvalid%0d", i), bus.master_resp_o[i].rvalid, ev);
            if (ev) check($sformatf("rdata%0d", i), bus.master_resp_o[i].rdata, s_rdata);
        end
        check("outstanding", bus.outstanding_o, rst_n ? q.size() : 0);
        check("spurious", bus.spurious_rvalid_o, spur);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            rr = 0; lk = 0; lk_idx = 0; spur = 0;
            q.delete();
        end else begin
            spur = s_rvalid && (q.size() == 0);
            if (s_rvalid && q.size() > 0) void'(q.pop_front());
            if (e_req && s_gnt) begin
                q.push_back(e_sel);
                lk = 0;
                rr = (e_sel + 1) % NM;
                m_req[e_sel] = 1'b0;
            end else if (e_req) begin
                lk = 1;
                lk_idx = e_sel;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        apply_and_check();
        tick();
    endtask

    task automatic set_req(input int i, input logic [31:0] a);
        m_req[i]   = 1'b1;
        m_addr[i]  = a;
        m_wdata[i] = ~a;
        m_we[i]    = a[4];
        m_be[i]    = a[3:0];
    endtask

    task automatic idle_all();
        for (int i = 0; i < NM; i++) m_req[i] = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        s_gnt = 0; s_rvalid = 0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        idle_all();
        s_rvalid = 1'b1;
        for (int n = 0; n < 8 && q.size() > 0; n++) begin
            s_rdata = $urandom;
            step();
        end
        s_rvalid = 1'b0;
    endtask

    initial begin
        rr = 0; lk = 0; lk_idx = 0; spur = 0;
        for (int i = 0; i < NM; i++) begin
            m_req[i] = 0; m_we[i] = 0; m_be[i] = 0;
            m_addr[i] = 0; m_wdata[i] = 0;
        end
        s_gnt = 0; s_rvalid = 0; s_rdata = 0;
        @(negedge clk);
        bus.master_req_i = '0;
        bus.slave_resp_i = '0;
        tick();
        do_reset();

        // Grant order 0,1 then stall on full
        set_req(0, 32'h100); set_req(1, 32'h200); set_req(2, 32'h300);
        s_gnt = 1;
        apply_and_check(); check("ordA_g0", bus.master_resp_o[0].gnt, 1'b1); tick();
        apply_and_check(); check("ordA_g1", bus.master_resp_o[1].gnt, 1'b1); tick();
        apply_and_check(); check("ordA_full", bus.slave_req_o.req, 1'b0);
        check("ordA_cnt", bus.outstanding_o, 2); tick();
        drain();

        // Lock holds master 1 against a later master 0
        do_reset();
        set_req(1, 32'h1111_0000); s_gnt = 0;
        step();
        set_req(0, 32'h0000_AAAA);
        apply_and_check(); check("lock_addr", bus.slave_req_o.addr, 32'h1111_0000); tick();
        apply_and_check(); check("lock_addr2", bus.slave_req_o.addr, 32'h1111_0000); tick();
        s_gnt = 1;
        apply_and_check(); check("lock_g1", bus.master_resp_o[1].gnt, 1'b1); tick();
        apply_and_check(); check("wrap_g0", bus.master_resp_o[0].gnt, 1'b1); tick();
        drain();

        // Response routing to masters 2 then 0
        do_reset();
        s_gnt = 1; set_req(2, 32'h2000);
        apply_and_check(); check("rt_g2", bus.master_resp_o[2].gnt, 1'b1); tick();
        set_req(0, 32'h0040);
        apply_and_check(); check("rt_cnt1", bus.outstanding_o, 1); tick();
        s_rvalid = 1; s_rdata = 32'hA5A5_0001;
        apply_and_check(); check("rt_cnt2", bus.outstanding_o, 2);
        check("rt_rv2", bus.master_resp_o[2].rvalid, 1'b1); tick();
        s_rdata = 32'hA5A5_0002;
        apply_and_check(); check("rt_cnt1b", bus.outstanding_o, 1);
        check("rt_rv0", bus.master_resp_o[0].rvalid, 1'b1);
        check("rt_rd0", bus.master_resp_o[0].rdata, 32'hA5A5_0002); tick();
        s_rvalid = 0;
        apply_and_check(); check("rt_cnt0", bus.outstanding_o, 0); tick();

        // Full plus same-cycle pop: no grant until next cycle
        set_req(1, 32'h3000); step();
        set_req(2, 32'h3100); step();
        set_req(0, 32'h3200); s_rvalid = 1; s_rdata = 32'h5A5A_0003;
        apply_and_check(); check("fp_noreq", bus.slave_req_o.req, 1'b0);
        check("fp_rv1", bus.master_resp_o[1].rvalid, 1'b1); tick();
        s_rvalid = 0;
        apply_and_check(); check("fp_g0", bus.master_resp_o[0].gnt, 1'b1); tick();
        apply_and_check(); check("fp_cnt", bus.outstanding_o, 2); tick();
        drain();

        // Spurious response with empty FIFO
        s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
        step();
        s_rvalid = 0;
        apply_and_check(); check("sp_pulse", bus.spurious_rvalid_o, 1'b1);
        check("sp_cnt", bus.outstanding_o, 0); tick();
        apply_and_check(); check("sp_clear", bus.spurious_rvalid_o, 1'b0); tick();

        // Reset while locked with one outstanding
        s_gnt = 1; set_req(0, 32'h4000); step();
        s_gnt = 0; set_req(1, 32'h4100); step();
        rst_n = 0; idle_all();
        apply_and_check(); check("rs_cnt", bus.outstanding_o, 0); tick();
        rst_n = 1; s_gnt = 1; set_req(2, 32'h4200);
        apply_and_check(); check("rs_g2", bus.master_resp_o[2].gnt, 1'b1);
        check("rs_addr", bus.slave_req_o.addr, 32'h4200); tick();
        drain();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NM; i++)
                if (!m_req[i] && $urandom_range(0, 2) == 0) set_req(i, $urandom);
            s_gnt    = ($urandom_range(0, 3) != 0);
            s_rvalid = ($urandom_range(0, 2) == 0);
            s_rdata  = $urandom;
            rst_n    = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
